load_store_unit: RTL and testbench

//  Sequences one load/store at a time from the core's execute stage into the data memory / MMIO block
//  (dmem_* port set, 1-cycle synchronous read, funct3-coded width/sign).

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_access_check.sv | 21 ++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and funct3 encodings for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;
endpackage

// File: rtl/lsu_access_check.sv
// lsu_access_check: flags illegal funct3 or misaligned half/word accesses
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic       is_store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       fault
);
  logic legal;
  logic misaligned;
  always_comb begin
    legal = is_store ? (funct3 inside {F3_B, F3_H, F3_W})
                     : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = CHECK_ALIGN && ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
                                 (funct3[1:0] == 2'b10 && addr_lo != 2'b00));
    fault = !legal || misaligned;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time into a 1-cycle synchronous data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1,
  parameter bit STORE_ACK   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_we,
  output logic        resp_fault,
  output logic [31:0] fault_addr,
  output logic [2:0]  dmem_funct3,
  output logic        dmem_wren,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out
);
  lsu_state_t  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_we_q, resp_we_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        fault;

  lsu_access_check #(.CHECK_ALIGN(CHECK_ALIGN)) u_check (
    .is_store (req_is_store),
    .funct3   (req_funct3),
    .addr_lo  (req_addr[1:0]),
    .fault    (fault)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_we_d    = resp_we_q;
    resp_fault_d = resp_fault_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      IDLE: if (req_valid) begin
        req_d = '{is_store: req_is_store, funct3: req_funct3, addr: req_addr,
                  wdata: req_wdata, rd: req_rd};
        resp_fault_d = fault;
        resp_data_d  = '0;
        resp_we_d    = !req_is_store && !fault && req_rd != 5'd0;
        resp_valid_d = fault;
        fault_addr_d = fault ? req_addr : fault_addr_q;
        state_d      = fault ? RESP : ACCESS;
      end
      ACCESS: begin
        state_d      = !req_q.is_store ? CAPTURE : STORE_ACK ? RESP : IDLE;
        resp_valid_d = req_q.is_store && STORE_ACK;
      end
      CAPTURE: begin
        resp_data_d  = dmem_data_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_we_q    <= 1'b0;
      resp_fault_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_we_q    <= resp_we_d;
      resp_fault_q <= resp_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Reset gates the write strobe directly so an access cut short by reset never writes.
  assign dmem_wren    = state_q == ACCESS && req_q.is_store && !reset;
  assign req_ready    = state_q == IDLE;
  assign dmem_address = req_q.addr;
  assign dmem_funct3  = req_q.funct3;
  assign dmem_data_in = req_q.wdata;
  assign resp_rd      = req_q.rd;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_we      = resp_we_q;
  assign resp_fault   = resp_fault_q;
  assign fault_addr   = fault_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-addressed synchronous memory model
module tb_load_store_unit;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_we, resp_fault;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, fault_addr;
  logic [2:0]  dmem_funct3;
  logic        dmem_wren;
  logic [31:0] dmem_address, dmem_data_in, dmem_data_out;

  logic [7:0]  mem [0:4095];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = '0, pl_data = '0;
  int          tests = 0, fails = 0, cyc = 0, wr_count = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  logic [2:0]  last_wf = '0;
  int          acc[$];
  resp_t       sb[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_we(resp_we), .resp_fault(resp_fault), .fault_addr(fault_addr),
    .dmem_funct3(dmem_funct3), .dmem_wren(dmem_wren), .dmem_address(dmem_address),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[11:0]];
    b1 = mem[a[11:0] + 12'd1];
    b2 = mem[a[11:0] + 12'd2];
    b3 = mem[a[11:0] + 12'd3];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dmem_data_out <= mem_read(dmem_address, dmem_funct3);
    if (pl_en)
      for (int i = 0; i < 4; i++) mem[pl_addr[11:0] + 12'(i)] <= pl_data[8*i +: 8];
    if (dmem_wren) begin
      wr_count <= wr_count + 1;
      last_wa  <= dmem_address;
      last_wf  <= dmem_funct3;
      last_wd  <= dmem_data_in;
      for (int i = 0; i < 4; i++)
        if (i == 0 || (i == 1 && dmem_funct3[1:0] != 2'b00) || dmem_funct3[1:0] == 2'b10)
          mem[dmem_address[11:0] + 12'(i)] <= dmem_data_in[8*i +: 8];
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = w;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic exp_resp, input resp_t e);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready addr=%h: req_ready=%b, required 1", a, req_ready);
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    acc.push_back(cyc);
    if (exp_resp) sb.push_back(e);
  endtask

  task automatic get_resp(output int lat, output resp_t o, output resp_t e);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 30);
    o = '{resp_rd, resp_data, resp_we, resp_fault};
    e = (sb.size() > 0) ? sb.pop_front() : resp_t'{5'h1f, 32'hBAD0BAD0, 1'bx, 1'bx};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_we, resp_fault, dmem_wren} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: rdy/val/we/flt/wren=%b, required 10000",
               {req_ready, resp_valid, resp_we, resp_fault, dmem_wren});
    end
    tests++;
    if ({resp_data, fault_addr, dmem_address, dmem_data_in} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: data=%h fault_addr=%h addr=%h din=%h, required all 0",
               resp_data, fault_addr, dmem_address, dmem_data_in);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_word();
    int lat; resp_t o, e;
    preload(32'h100, 32'hDEADBEEF);
    resp_ready = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, resp_t'{5'd5, 32'hDEADBEEF, 1'b1, 1'b0});
    get_resp(lat, o, e);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL lw_latency: %0d cycles, required 3", lat); end
    tests++;
    if (o !== e) begin fails++; $display("FAIL lw_resp: got %h, required %h", o, e); end
  endtask

  task automatic test_store_byte();
    int lat, w0; resp_t o, e;
    w0 = wr_count;
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1'b1, resp_t'{5'd0, 32'h0, 1'b0, 1'b0});
    get_resp(lat, o, e);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL sb_latency: %0d cycles, required 2", lat); end
    tests++;
    if (o !== e) begin fails++; $display("FAIL sb_resp: got %h, required %h", o, e); end
    tests++;
    if (wr_count - w0 !== 1) begin
      fails++; $display("FAIL sb_wren_cycles: %0d, required 1", wr_count - w0);
    end
    tests++;
    if ({last_wa, last_wf, last_wd[7:0]} !== {32'h103, 3'b000, 8'hA5}) begin
      fails++;
      $display("FAIL sb_mem_side: addr=%h f3=%b data=%h, required 103/000/a5", last_wa, last_wf, last_wd);
    end
    issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, resp_t'{5'd7, 32'h000000A5, 1'b1, 1'b0});
    get_resp(lat, o, e);
    tests++;
    if (o !== e) begin fails++; $display("FAIL lbu_after_sb: got %h, required %h", o, e); end
  endtask

  task automatic test_misaligned();
    int lat, w0; resp_t o, e;
    w0 = wr_count;
    issue(1'b0, 3'b001, 32'h101, 32'h0, 5'd3, 1'b1, resp_t'{5'd3, 32'h0, 1'b0, 1'b1});
    get_resp(lat, o, e);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL lh_fault_latency: %0d cycles, required 1", lat); end
    tests++;
    if (o !== e) begin fails++; $display("FAIL lh_fault_resp: got %h, required %h", o, e); end
    tests++;
    if (fault_addr !== 32'h101) begin
      fails++; $display("FAIL lh_fault_addr: %h, required 00000101", fault_addr);
    end
    issue(1'b1, 3'b010, 32'h106, 32'h1, 5'd0, 1'b1, resp_t'{5'd0, 32'h0, 1'b0, 1'b1});
    get_resp(lat, o, e);
    tests++;
    if (o !== e) begin fails++; $display("FAIL sw_misalign_resp: got %h, required %h", o, e); end
    tests++;
    if (wr_count !== w0) begin
      fails++; $display("FAIL misalign_no_write: %0d writes, required 0", wr_count - w0);
    end
  endtask

  task automatic test_backpressure();
    int lat; resp_t o, e;
    preload(32'hFFFFFFF8, 32'h12345678);
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'hFFFFFFF8, 32'h0, 5'd9, 1'b1, resp_t'{5'd9, 32'h12345678, 1'b1, 1'b0});
    get_resp(lat, o, e);
    tests++;
    if (o !== e || lat !== 3) begin
      fails++; $display("FAIL bp_first: got %h lat %0d, required %h lat 3", o, lat, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({resp_valid, req_ready, resp_data} !== {1'b1, 1'b0, 32'h12345678}) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h, required 1/0/12345678",
                 i, resp_valid, req_ready, resp_data);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release: valid=%b ready=%b, required 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_illegal_funct3();
    int lat, w0; resp_t o, e;
    w0 = wr_count;
    issue(1'b0, 3'b011, 32'h200, 32'h0, 5'd4, 1'b1, resp_t'{5'd4, 32'h0, 1'b0, 1'b1});
    get_resp(lat, o, e);
    tests++;
    if (o !== e || lat !== 1) begin
      fails++; $display("FAIL ld_f3_011: got %h lat %0d, required %h lat 1", o, lat, e);
    end
    tests++;
    if (fault_addr !== 32'h200) begin
      fails++; $display("FAIL ld_f3_011_addr: %h, required 00000200", fault_addr);
    end
    issue(1'b1, 3'b100, 32'h204, 32'h55, 5'd0, 1'b1, resp_t'{5'd0, 32'h0, 1'b0, 1'b1});
    get_resp(lat, o, e);
    tests++;
    if (o !== e || lat !== 1) begin
      fails++; $display("FAIL st_f3_100: got %h lat %0d, required %h lat 1", o, lat, e);
    end
    tests++;
    if (fault_addr !== 32'h204 || wr_count !== w0) begin
      fails++;
      $display("FAIL illegal_side: fault_addr=%h writes=%0d, required 00000204/0", fault_addr, wr_count - w0);
    end
  endtask

  task automatic test_reset_in_access();
    int w0;
    w0 = wr_count;
    issue(1'b1, 3'b010, 32'h300, 32'h11223344, 5'd0, 1'b0, resp_t'{5'd0, 32'h0, 1'b0, 1'b0});
    reset = 1'b1;
    #1;
    tests++;
    if (dmem_wren !== 1'b0) begin fails++; $display("FAIL rst_wren: %b, required 0", dmem_wren); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({req_ready, resp_valid} !== 2'b10 || wr_count !== w0) begin
      fails++;
      $display("FAIL rst_access: ready=%b valid=%b writes=%0d, required 1/0/0",
               req_ready, resp_valid, wr_count - w0);
    end
  endtask

  task automatic test_back_to_back();
    int d[6] = '{3, 3, 4, 4, 4, 4};
    resp_ready = 1'b1;
    acc.delete();
    fork
      begin
        issue(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0, 1'b1, resp_t'{5'd0, 32'h0, 1'b0, 1'b0});
        issue(1'b1, 3'b001, 32'h404, 32'h00008001, 5'd0, 1'b1, resp_t'{5'd0, 32'h0, 1'b0, 1'b0});
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd1, 1'b1, resp_t'{5'd1, 32'hCAFEF00D, 1'b1, 1'b0});
        issue(1'b0, 3'b101, 32'h402, 32'h0, 5'd2, 1'b1, resp_t'{5'd2, 32'h0000CAFE, 1'b1, 1'b0});
        issue(1'b0, 3'b000, 32'h400, 32'h0, 5'd3, 1'b1, resp_t'{5'd3, 32'h0000000D, 1'b1, 1'b0});
        issue(1'b0, 3'b001, 32'h404, 32'h0, 5'd4, 1'b1, resp_t'{5'd4, 32'hFFFF8001, 1'b1, 1'b0});
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd0, 1'b1, resp_t'{5'd0, 32'hCAFEF00D, 1'b0, 1'b0});
      end
      begin
        for (int i = 0; i < 7; i++) begin
          int lat; resp_t o, e;
          get_resp(lat, o, e);
          tests++;
          if (o !== e) begin fails++; $display("FAIL b2b_resp %0d: got %h, required %h", i, o, e); end
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (acc[i+1] - acc[i] !== d[i]) begin
        fails++; $display("FAIL b2b_interval %0d: %0d cycles, required %0d", i, acc[i+1] - acc[i], d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_misaligned();
    test_backpressure();
    test_illegal_funct3();
    test_reset_in_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
